// File: rtl/branch_pkg.sv
// Shared types for the branch stage: condition codes, FSM states and a
// helper that says whether a condition needs the comparator at all.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_LT     = 3'b010,
    COND_GE     = 3'b011,
    COND_LTU    = 3'b100,
    COND_GEU    = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  function automatic logic cond_needs_cmp(cond_t c);
    return !(c == COND_ALWAYS || c == COND_NEVER);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational flag derivation from a - b = d and condition-code evaluation.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] d,
  input  cond_t           cond,
  output logic            taken
);

  logic z, n, v, c;

  // c is a borrow: set when a < b unsigned
  assign z = (d == '0);
  assign n = d[XLEN-1];
  assign v = (a[XLEN-1] ^ b[XLEN-1]) & (d[XLEN-1] ^ a[XLEN-1]);
  assign c = (~a[XLEN-1] & b[XLEN-1]) | (~(a[XLEN-1] ^ b[XLEN-1]) & d[XLEN-1]);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_EQ:     taken = z;
      COND_NE:     taken = ~z;
      COND_LT:     taken = n ^ v;
      COND_GE:     taken = ~(n ^ v);
      COND_LTU:    taken = c;
      COND_GEU:    taken = ~c;
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch stage: issues operands to an external comparator, evaluates the
// condition on its difference and returns taken/next_pc. BRANCH_STATS_EN adds outcome counters.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int OFF_W  = 16,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             ready,
  input  logic [2:0]       cond,
  input  logic [XLEN-1:0]  rs_a,
  input  logic [XLEN-1:0]  rs_b,
  input  logic [XLEN-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  output logic [XLEN-1:0]  cmp_i1,
  output logic [XLEN-1:0]  cmp_i2,
  output logic             compen,
  input  logic [XLEN-1:0]  comp,
  output logic             valid,
  input  logic             ack,
  output logic             taken,
  output logic [XLEN-1:0]  next_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_taken,
  output logic [31:0]      stat_not_taken
`endif
);

  state_t           state, state_nxt;
  cond_t            cond_q;
  logic [XLEN-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;
  logic             taken_c;
  logic [XLEN-1:0]  target;

  branch_cond_eval #(.XLEN(XLEN)) u_eval (
    .a     (cmp_i1),
    .b     (cmp_i2),
    .d     (comp),
    .cond  (cond_q),
    .taken (taken_c)
  );

  assign target = pc_q + {{(XLEN-OFF_W){off_q[OFF_W-1]}}, off_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (req) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_RESOLVE;
      S_RESOLVE: if (ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q  <= COND_EQ;
      pc_q    <= '0;
      off_q   <= '0;
      cmp_i1  <= '0;
      cmp_i2  <= '0;
      compen  <= 1'b0;
      valid   <= 1'b0;
      taken   <= 1'b0;
      next_pc <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req) begin
          cond_q <= cond_t'(cond);
          pc_q   <= pc;
          off_q  <= offset;
          cmp_i1 <= rs_a;
          cmp_i2 <= rs_b;
          compen <= cond_needs_cmp(cond_t'(cond));
        end
        S_COMPARE: begin
          taken   <= taken_c;
          next_pc <= taken_c ? target : pc_q + XLEN'(PC_INC);
          compen  <= 1'b0;
          valid   <= 1'b1;
        end
        S_RESOLVE: if (ack) valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (state == S_COMPARE) begin
      if (taken_c) stat_taken     <= stat_taken + 32'd1;
      else         stat_not_taken <= stat_not_taken + 32'd1;
    end
  end
`endif

endmodule
